// File: rtl/irq_coalesce.sv
// irq_coalesce: interrupt coalescing controller for the RX DMA path.
// Counts committed-packet events and raises an interrupt request once either
// the packet threshold is reached or the pending batch has aged past the
// timeout. The request is held until the downstream IRQ generator acks it.
//
// Ports
//   clk       core clock, all logic on posedge
//   rst       synchronous, active-high reset
//   pkt_evt   one-cycle pulse per packet committed to host memory
//   reg_wr    host register write strobe
//   reg_addr  register select: 0 CTRL, 1 PKT_THR, 2 TIMEOUT, 3 HOLDOFF
//   reg_data  register write data
//   irq_ack   one-cycle handshake-complete pulse from the IRQ generator
//   send_irq  registered interrupt request level
//   irq_en    registered one-cycle host re-arm pulse (CTRL bit 1 write)
//   irq_dis   registered level, NOT CTRL.enable
//   irq_thr   HOLDOFF register value (post-IRQ dead time in cycles)
//   pending   current pending-event count (saturating)
//
// CNT_W must lie in 2..32 (PKT_THR is taken from reg_data[CNT_W-1:0]).
//
// state | meaning
// ------+--------------------------------------------------
// IDLE  | no pending events, timer parked
// COUNT | pending > 0, timer ageing the batch
// FIRE  | send_irq asserted, waiting for irq_ack

module irq_coalesce #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pkt_evt,
    input  logic             reg_wr,
    input  logic [1:0]       reg_addr,
    input  logic [31:0]      reg_data,
    input  logic             irq_ack,
    output logic             send_irq,
    output logic             irq_en,
    output logic             irq_dis,
    output logic [31:0]      irq_thr,
    output logic [CNT_W-1:0] pending
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_FIRE  = 2'd2
    } state_t;

    localparam logic [1:0]       A_CTRL    = 2'd0;
    localparam logic [1:0]       A_PKT_THR = 2'd1;
    localparam logic [1:0]       A_TIMEOUT = 2'd2;
    localparam logic [1:0]       A_HOLDOFF = 2'd3;
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [31:0]      TMR_MAX   = 32'hFFFF_FFFF;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] pending_q, pending_d;
    logic [31:0]      timer_q, timer_d;
    logic             send_irq_q;
    logic             irq_en_q;

    logic             enable_q;
    logic [CNT_W-1:0] pkt_thr_q;
    logic [31:0]      timeout_q;
    logic [31:0]      holdoff_q;

    logic [CNT_W:0]   evt_sum;
    logic [CNT_W:0]   thr_eff;
    logic [CNT_W-1:0] pending_inc;
    logic [31:0]      timer_inc;
    logic             thr_hit;
    logic             tmo_hit;

    // Shared arithmetic. Register values are the pre-write ones, so a write
    // landing in the same cycle as an event only affects later decisions.
    always_comb begin
        evt_sum     = {1'b0, pending_q} + {{CNT_W{1'b0}}, pkt_evt};
        thr_eff     = (pkt_thr_q == '0) ? {1'b0, CNT_ONE} : {1'b0, pkt_thr_q};
        thr_hit     = (evt_sum >= thr_eff);
        tmo_hit     = (timeout_q != '0) && (timer_q >= (timeout_q - 32'd1));
        // The carry out of evt_sum only occurs when pending is already at max.
        pending_inc = evt_sum[CNT_W] ? CNT_MAX : evt_sum[CNT_W-1:0];
        timer_inc   = (timer_q == TMR_MAX) ? TMR_MAX : (timer_q + 32'd1);
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        timer_d   = timer_q;
        case (state_q)
            ST_IDLE: begin
                if (pkt_evt) begin
                    pending_d = pending_inc;
                    timer_d   = '0;
                    state_d   = (enable_q && thr_hit) ? ST_FIRE : ST_COUNT;
                end
            end
            ST_COUNT: begin
                timer_d   = timer_inc;
                pending_d = pending_inc;
                if (enable_q && (thr_hit || tmo_hit)) begin
                    state_d = ST_FIRE;
                end
            end
            ST_FIRE: begin
                if (irq_ack) begin
                    // An event coincident with the ack starts the next batch.
                    pending_d = pkt_evt ? CNT_ONE : '0;
                    timer_d   = '0;
                    state_d   = pkt_evt ? ST_COUNT : ST_IDLE;
                end else begin
                    pending_d = pending_inc;
                    if (!enable_q) begin
                        state_d = (pending_inc == '0) ? ST_IDLE : ST_COUNT;
                    end
                end
            end
            default: begin
                state_d   = ST_IDLE;
                pending_d = '0;
                timer_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pending_q  <= '0;
            timer_q    <= '0;
            send_irq_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            timer_q    <= timer_d;
            send_irq_q <= (state_d == ST_FIRE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            enable_q  <= 1'b0;
            pkt_thr_q <= CNT_ONE;
            timeout_q <= '0;
            holdoff_q <= '0;
            irq_en_q  <= 1'b0;
        end else begin
            // Re-arm is a write-1 pulse and is never stored.
            irq_en_q <= reg_wr && (reg_addr == A_CTRL) && reg_data[1];
            if (reg_wr) begin
                case (reg_addr)
                    A_CTRL:    enable_q  <= reg_data[0];
                    A_PKT_THR: pkt_thr_q <= reg_data[CNT_W-1:0];
                    A_TIMEOUT: timeout_q <= reg_data;
                    A_HOLDOFF: holdoff_q <= reg_data;
                    default:   enable_q  <= enable_q;
                endcase
            end
        end
    end

    assign send_irq = send_irq_q;
    assign irq_en   = irq_en_q;
    assign irq_dis  = ~enable_q;
    assign irq_thr  = holdoff_q;
    assign pending  = pending_q;

endmodule

// File: tb/tb_irq_coalesce.sv
// Testbench for irq_coalesce. Two instances (CNT_W=16 and CNT_W=4) share
// one stimulus stream. After every clock a reference model derived from the
// coalescing rules pushes the expected outputs into a queue; a monitor on the
// falling edge pops and compares. Directed phases add latency and boundary
// checks against fixed numbers, followed by a randomized phase.

module tb_irq_coalesce;

    logic        clk;
    logic        rst;
    logic        pkt_evt;
    logic        reg_wr;
    logic [1:0]  reg_addr;
    logic [31:0] reg_data;
    logic        irq_ack;

    logic        send0, ien0, dis0;
    logic [31:0] thr0;
    logic [15:0] pend0;
    logic        send1, ien1, dis1;
    logic [31:0] thr1;
    logic [3:0]  pend1;

    irq_coalesce #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .pkt_evt(pkt_evt), .reg_wr(reg_wr),
        .reg_addr(reg_addr), .reg_data(reg_data), .irq_ack(irq_ack),
        .send_irq(send0), .irq_en(ien0), .irq_dis(dis0),
        .irq_thr(thr0), .pending(pend0)
    );

    irq_coalesce #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .pkt_evt(pkt_evt), .reg_wr(reg_wr),
        .reg_addr(reg_addr), .reg_data(reg_data), .irq_ack(irq_ack),
        .send_irq(send1), .irq_en(ien1), .irq_dis(dis1),
        .irq_thr(thr1), .pending(pend1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    localparam longint TMAX = 64'h0000_0000_FFFF_FFFF;

    bit     m_fire  [2];
    longint m_pend  [2];
    longint m_timer [2];
    longint m_thr   [2];
    longint m_maxp  [2];
    bit     m_en;
    bit     m_ien;
    longint m_tmo;
    longint m_hold;

    typedef struct {
        bit     send0;
        bit     send1;
        longint pend0;
        longint pend1;
        bit     ien;
        bit     dis;
        longint hold;
    } exp_t;

    exp_t sb_q[$];

    task automatic model_step(input bit r, input bit e, input bit w,
                              input logic [1:0] a, input logic [31:0] d,
                              input bit k);
        exp_t x;
        longint thr, sum, sat;
        bit hit;
        if (r) begin
            for (int i = 0; i < 2; i++) begin
                m_fire[i]  = 1'b0;
                m_pend[i]  = 0;
                m_timer[i] = 0;
                m_thr[i]   = 1;
            end
            m_en   = 1'b0;
            m_ien  = 1'b0;
            m_tmo  = 0;
            m_hold = 0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                thr = (m_thr[i] == 0) ? 1 : m_thr[i];
                sum = m_pend[i] + longint'(e);
                sat = (sum > m_maxp[i]) ? m_maxp[i] : sum;
                if (m_fire[i]) begin
                    if (k) begin
                        m_pend[i]  = longint'(e);
                        m_timer[i] = 0;
                        m_fire[i]  = 1'b0;
                    end else begin
                        m_pend[i] = sat;
                        if (!m_en) m_fire[i] = 1'b0;
                    end
                end else if (m_pend[i] == 0) begin
                    if (e) begin
                        m_pend[i]  = 1;
                        m_timer[i] = 0;
                        if (m_en && thr <= 1) m_fire[i] = 1'b1;
                    end
                end else begin
                    hit = m_en && ((sum >= thr) ||
                                   (m_tmo != 0 && m_timer[i] >= m_tmo - 1));
                    m_timer[i] = (m_timer[i] >= TMAX) ? TMAX : m_timer[i] + 1;
                    m_pend[i]  = sat;
                    if (hit) m_fire[i] = 1'b1;
                end
            end
            m_ien = 1'b0;
            if (w) begin
                case (a)
                    2'd0: begin m_en = d[0]; m_ien = d[1]; end
                    2'd1: begin m_thr[0] = longint'(d[15:0]); m_thr[1] = longint'(d[3:0]); end
                    2'd2: m_tmo = longint'(d);
                    default: m_hold = longint'(d);
                endcase
            end
        end
        x.send0 = m_fire[0];
        x.send1 = m_fire[1];
        x.pend0 = m_pend[0];
        x.pend1 = m_pend[1];
        x.ien   = m_ien;
        x.dis   = !m_en;
        x.hold  = m_hold;
        sb_q.push_back(x);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t x;
        if (sb_q.size() > 0) begin
            x = sb_q.pop_front();
            chk("send_irq16", longint'(send0), longint'(x.send0));
            chk("send_irq4",  longint'(send1), longint'(x.send1));
            chk("pending16",  longint'(pend0), x.pend0);
            chk("pending4",   longint'(pend1), x.pend1);
            chk("irq_en16",   longint'(ien0),  longint'(x.ien));
            chk("irq_en4",    longint'(ien1),  longint'(x.ien));
            chk("irq_dis16",  longint'(dis0),  longint'(x.dis));
            chk("irq_dis4",   longint'(dis1),  longint'(x.dis));
            chk("irq_thr16",  longint'(thr0),  x.hold);
            chk("irq_thr4",   longint'(thr1),  x.hold);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cycle(input bit r, input bit e, input bit w,
                         input logic [1:0] a, input logic [31:0] d, input bit k);
        @(negedge clk);
        rst      = r;
        pkt_evt  = e;
        reg_wr   = w;
        reg_addr = a;
        reg_data = d;
        irq_ack  = k;
        @(posedge clk);
        #1;
        model_step(r, e, w, a, d, k);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 1'b0);
    endtask

    task automatic evt();
        cycle(1'b0, 1'b1, 1'b0, 2'd0, 32'd0, 1'b0);
    endtask

    task automatic ack();
        cycle(1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 1'b1);
    endtask

    task automatic wreg(input logic [1:0] a, input logic [31:0] d);
        cycle(1'b0, 1'b0, 1'b1, a, d, 1'b0);
    endtask

    // Idles until send_irq (16-bit instance) rises; returns the cycle count.
    task automatic wait_fire(input int limit, output int n);
        n = 0;
        while (!send0 && n < limit) begin
            idle();
            n++;
        end
    endtask

    initial begin
        int n;
        bit r, e, w, k;
        logic [1:0]  a;
        logic [31:0] d;

        m_maxp[0] = 65535;
        m_maxp[1] = 15;
        rst = 1'b1; pkt_evt = 1'b0; reg_wr = 1'b0;
        reg_addr = 2'd0; reg_data = 32'd0; irq_ack = 1'b0;

        // Reset state
        repeat (3) cycle(1'b1, 1'b0, 1'b0, 2'd0, 32'd0, 1'b0);
        idle();
        chk("rst_irq_dis", longint'(dis0), 1);
        chk("rst_send_irq", longint'(send0), 0);
        chk("rst_pending", longint'(pend0), 0);
        chk("rst_irq_thr", longint'(thr0), 0);

        // Threshold path
        wreg(2'd0, 32'h1);
        wreg(2'd1, 32'd4);
        wreg(2'd2, 32'd0);
        wreg(2'd3, 32'hDEAD_BEEF);
        chk("holdoff", longint'(thr0), longint'(32'hDEAD_BEEF));
        repeat (3) evt();
        chk("thr_not_yet", longint'(send0), 0);
        evt();
        chk("thr_fire", longint'(send0), 1);
        chk("thr_pending", longint'(pend0), 4);
        ack();
        chk("ack_send", longint'(send0), 0);
        chk("ack_pending", longint'(pend0), 0);

        // PKT_THR=0 behaves as 1: IDLE straight to FIRE
        wreg(2'd1, 32'd0);
        evt();
        chk("thr0_fire", longint'(send0), 1);
        ack();

        // Timeout path
        wreg(2'd1, 32'd100);
        wreg(2'd2, 32'd50);
        evt();
        wait_fire(200, n);
        chk("tmo_latency", longint'(n), 50);
        chk("tmo_pending", longint'(pend0), 1);

        // Event coincident with ack restarts the batch and the timer
        cycle(1'b0, 1'b1, 1'b0, 2'd0, 32'd0, 1'b1);
        chk("reload_pending", longint'(pend0), 1);
        chk("reload_send", longint'(send0), 0);
        wait_fire(200, n);
        chk("reload_latency", longint'(n), 50);
        ack();

        // Disabled counting, then enable with re-arm
        wreg(2'd2, 32'd0);
        wreg(2'd1, 32'd4);
        wreg(2'd0, 32'h0);
        repeat (10) evt();
        chk("dis_send", longint'(send0), 0);
        chk("dis_pending", longint'(pend0), 10);
        wreg(2'd0, 32'h3);
        chk("rearm_pulse", longint'(ien0), 1);
        chk("rearm_dis", longint'(dis0), 0);
        chk("rearm_send_low", longint'(send0), 0);
        idle();
        chk("rearm_pulse_end", longint'(ien0), 0);
        chk("rearm_send", longint'(send0), 1);

        // Enable dropped while firing
        wreg(2'd0, 32'h0);
        idle();
        chk("drop_send", longint'(send0), 0);
        chk("drop_pending", longint'(pend0), 10);
        wreg(2'd0, 32'h1);
        idle();
        chk("reen_send", longint'(send0), 1);
        ack();

        // Saturation on the narrow instance, then reset mid-FIRE
        wreg(2'd0, 32'h0);
        repeat (20) evt();
        chk("sat_pending4", longint'(pend1), 15);
        chk("sat_pending16", longint'(pend0), 20);
        wreg(2'd0, 32'h1);
        idle();
        chk("sat_fire4", longint'(send1), 1);
        cycle(1'b1, 1'b0, 1'b0, 2'd0, 32'd0, 1'b0);
        chk("rst_fire_send4", longint'(send1), 0);
        chk("rst_fire_pending4", longint'(pend1), 0);
        chk("rst_fire_send16", longint'(send0), 0);

        // Randomized traffic
        wreg(2'd0, 32'h1);
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 399) == 0);
            e = ($urandom_range(0, 2) == 0);
            k = ($urandom_range(0, 3) == 0);
            w = ($urandom_range(0, 9) == 0);
            a = 2'($urandom_range(0, 3));
            case (a)
                2'd0:    d = ($urandom_range(0, 1) == 1) ? 32'h3 : 32'h1;
                2'd1:    d = 32'($urandom_range(0, 20));
                2'd2:    d = 32'($urandom_range(0, 30));
                default: d = 32'($urandom);
            endcase
            cycle(r, e, w, a, d, k);
        end

        @(negedge clk);
        #1;
        chk("scoreboard_drained", longint'(sb_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
